// File: rtl/mptw_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mptw_req_arbiter
//  Function : Round-robin arbiter feeding one registered output slot of the
//             MPT walker, with valid/ready downstream handshake and flush.
//  Revision : 1.0 - initial release
// ============================================================================
module mptw_req_arbiter #(
    parameter  int NUM_REQ    = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            s_req_valid_i,
    output logic [NUM_REQ-1:0]            s_req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_req_data_i,
    output logic                          m_data_valid_o,
    input  logic                          m_data_ready_i,
    output logic [DATA_WIDTH-1:0]         m_data_data_o,
    output logic [IDX_WIDTH-1:0]          m_data_id_o,
    input  logic                          flush_i,
    output logic                          m_status_busy_o,
    output logic                          m_status_flushed_o
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [IDX_WIDTH-1:0]  r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_WIDTH-1:0]  w_grant;
    logic                  w_found;
    logic                  w_any_req;
    logic                  w_accept;
    int                    w_idx;
    logic [DATA_WIDTH-1:0] w_payload [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_payload[gi] = s_req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Search starts at the rotating pointer and wraps, so the first hit wins.
    always_comb begin : p_select
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && s_req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_grant = IDX_WIDTH'(w_idx);
            end
        end
    end

    assign w_any_req     = |s_req_valid_i;
    assign w_accept      = w_any_req && !flush_i && ((r_state == ST_EMPTY) || m_data_ready_i);
    assign s_req_ready_o = w_accept ? (NUM_REQ'(1) << w_grant) : '0;

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && m_data_ready_i) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Flush clears the slot contents but deliberately leaves the pointer alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_data <= '0;
                r_id   <= '0;
            end else if (w_accept) begin
                r_data <= w_payload[w_grant];
                r_id   <= w_grant;
                r_ptr  <= (w_grant == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + IDX_WIDTH'(1);
            end
        end
    end

    assign m_data_valid_o     = (r_state == ST_FULL);
    assign m_status_busy_o    = (r_state == ST_FULL);
    assign m_data_data_o      = r_data;
    assign m_data_id_o        = r_id;
    assign m_status_flushed_o = flush_i;

endmodule
`default_nettype wire

// File: tb/tb_mptw_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mptw_req_arbiter
//  Function : Self-checking bench: directed vector table, reset corner case
//             and randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mptw_req_arbiter;

    localparam int C_N  = 3;
    localparam int C_DW = 32;

    logic              clk_i;
    logic              rst_ni;
    logic [C_N-1:0]    s_req_valid_i;
    logic [C_N-1:0]    s_req_ready_o;
    logic [C_N*C_DW-1:0] s_req_data_i;
    logic              m_data_valid_o;
    logic              m_data_ready_i;
    logic [C_DW-1:0]   m_data_data_o;
    logic [1:0]        m_data_id_o;
    logic              flush_i;
    logic              m_status_busy_o;
    logic              m_status_flushed_o;

    mptw_req_arbiter #(.NUM_REQ(C_N), .DATA_WIDTH(C_DW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .s_req_valid_i      (s_req_valid_i),
        .s_req_ready_o      (s_req_ready_o),
        .s_req_data_i       (s_req_data_i),
        .m_data_valid_o     (m_data_valid_o),
        .m_data_ready_i     (m_data_ready_i),
        .m_data_data_o      (m_data_data_o),
        .m_data_id_o        (m_data_id_o),
        .flush_i            (flush_i),
        .m_status_busy_o    (m_status_busy_o),
        .m_status_flushed_o (m_status_flushed_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [2:0]  valid;
        logic [95:0] data;
        logic        rdy;
        logic        flush;
        logic [2:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [31:0] exp_data;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs [$];

    // Behavioural model: one optional held item plus a rotating start index.
    int          mdl_ptr;
    bit          mdl_full;
    logic [31:0] mdl_data;
    int          mdl_id;

    localparam logic [95:0] D_ALL = {32'h33, 32'h22, 32'h11};
    localparam logic [95:0] D_A5  = {32'h0, 32'hA5, 32'h0};

    function automatic vec_t mk(input logic [2:0] v, input logic [95:0] d, input logic r,
                                input logic f, input logic [2:0] er, input logic ev,
                                input logic [1:0] eid, input logic [31:0] ed);
        vec_t t;
        t.valid = v; t.data = d; t.rdy = r; t.flush = f;
        t.exp_ready = er; t.exp_valid = ev; t.exp_id = eid; t.exp_data = ed;
        return t;
    endfunction

    task automatic check(input string name, input logic [2:0] er, input logic ev,
                         input logic [1:0] eid, input logic [31:0] ed, input logic efl);
        n_vec++;
        if (s_req_ready_o !== er || m_data_valid_o !== ev || m_status_busy_o !== ev ||
            m_data_id_o !== eid || m_data_data_o !== ed || m_status_flushed_o !== efl) begin
            n_bad++;
            $display("FAIL %s: got ready=%b valid=%b busy=%b id=%0d data=%h flushed=%b, required ready=%b valid=%b busy=%b id=%0d data=%h flushed=%b",
                     name, s_req_ready_o, m_data_valid_o, m_status_busy_o, m_data_id_o,
                     m_data_data_o, m_status_flushed_o, er, ev, ev, eid, ed, efl);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [95:0] d, input logic r, input logic f);
        s_req_valid_i  = v;
        s_req_data_i   = d;
        m_data_ready_i = r;
        flush_i        = f;
    endtask

    task automatic do_reset();
        drive(3'b000, '0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        mdl_ptr = 0; mdl_full = 0; mdl_data = '0; mdl_id = 0;
    endtask

    task automatic model_step(input logic [2:0] v, input logic [95:0] d, input logic r,
                              input logic f, output logic [2:0] er);
        int  g;
        bit  acc;
        g = -1;
        for (int k = 0; k < C_N; k++) begin
            if (g < 0 && v[(mdl_ptr + k) % C_N]) g = (mdl_ptr + k) % C_N;
        end
        acc = (v != 0) && !f && (!mdl_full || r);
        er  = acc ? 3'(1 << g) : 3'b000;
        if (f) begin
            mdl_full = 0; mdl_data = '0; mdl_id = 0;
        end else if (acc) begin
            mdl_full = 1;
            mdl_data = d[g*32 +: 32];
            mdl_id   = g;
            mdl_ptr  = (g + 1) % C_N;
        end else if (mdl_full && r) begin
            mdl_full = 0;
        end
    endtask

    initial begin
        logic [2:0]  er;
        logic [2:0]  rv;
        logic [95:0] rd;
        logic        rr;
        logic        rf;
        logic [31:0] pd;
        logic [1:0]  pid;
        logic        pv;

        // Idle, full contention, single request, backpressure, flush, post-flush order.
        vecs.push_back(mk(3'b000, D_ALL, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 32'h00));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b001, 1'b0, 2'd0, 32'h00));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b010, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b100, 1'b1, 2'd1, 32'h22));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b001, 1'b1, 2'd2, 32'h33));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b010, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b100, 1'b1, 2'd1, 32'h22));
        vecs.push_back(mk(3'b000, D_ALL, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2, 32'h33));
        vecs.push_back(mk(3'b010, D_A5,  1'b1, 1'b0, 3'b010, 1'b0, 2'd2, 32'h33));
        vecs.push_back(mk(3'b000, D_A5,  1'b1, 1'b0, 3'b000, 1'b1, 2'd1, 32'hA5));
        vecs.push_back(mk(3'b000, D_A5,  1'b1, 1'b0, 3'b000, 1'b0, 2'd1, 32'hA5));
        vecs.push_back(mk(3'b001, D_ALL, 1'b1, 1'b0, 3'b001, 1'b0, 2'd1, 32'hA5));
        vecs.push_back(mk(3'b110, D_ALL, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b110, D_ALL, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b110, D_ALL, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b110, D_ALL, 1'b1, 1'b0, 3'b010, 1'b1, 2'd0, 32'h11));
        vecs.push_back(mk(3'b100, D_ALL, 1'b1, 1'b1, 3'b000, 1'b1, 2'd1, 32'h22));
        vecs.push_back(mk(3'b000, D_ALL, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 32'h00));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b0, 3'b100, 1'b0, 2'd0, 32'h00));
        vecs.push_back(mk(3'b000, D_ALL, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2, 32'h33));
        vecs.push_back(mk(3'b111, D_ALL, 1'b1, 1'b1, 3'b000, 1'b0, 2'd2, 32'h33));
        vecs.push_back(mk(3'b000, D_ALL, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 32'h00));

        do_reset();
        #1 check("reset_state", 3'b000, 1'b0, 2'd0, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_i);
            #1 drive(vecs[i].valid, vecs[i].data, vecs[i].rdy, vecs[i].flush);
            #2 check($sformatf("table[%0d]", i), vecs[i].exp_ready, vecs[i].exp_valid,
                     vecs[i].exp_id, vecs[i].exp_data, vecs[i].flush);
        end

        // Asynchronous reset while holding an item.
        @(posedge clk_i);
        #1 drive(3'b001, D_ALL, 1'b0, 1'b0);
        @(posedge clk_i);
        #1 drive(3'b000, D_ALL, 1'b0, 1'b0);
        #2 check("full_before_reset", 3'b000, 1'b1, 2'd0, 32'h11, 1'b0);
        #1 rst_ni = 1'b0;
        #1 check("async_reset_drop", 3'b000, 1'b0, 2'd0, 32'h0, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #2 check("post_reset_idle", 3'b000, 1'b0, 2'd0, 32'h0, 1'b0);
        #1 drive(3'b111, D_ALL, 1'b1, 1'b0);
        #1 check("post_reset_grant0", 3'b001, 1'b0, 2'd0, 32'h0, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i);
            rv = 3'($urandom_range(0, 7));
            rd = {$urandom(), $urandom(), $urandom()};
            rr = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 15) == 0);
            #1 drive(rv, rd, rr, rf);
            pv  = mdl_full;
            pid = 2'(mdl_id);
            pd  = mdl_data;
            model_step(rv, rd, rr, rf, er);
            #2 check($sformatf("random[%0d]", i), er, pv, pid, pd, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mptw_req_arbiter.md
Name: mptw_req_arbiter

Overview:
- Round-robin arbiter that shares one registered pipeline stage among NUM_REQ requesters of the MPT walker (e.g. instruction-side, data-side and refill paths).
- Picks one valid requester per accepted slot and latches its payload and requester index into a single-entry output register.
- Drives the downstream stage through a valid/ready handshake.
- Supports a synchronous flush and reports busy/flushed status with the same semantics as the other pipeline stages.

Parameters:
- NUM_REQ, 3, number of requesters (>= 2).
- DATA_WIDTH, 32, payload width per requester.
- IDX_WIDTH, $clog2(NUM_REQ), derived localparam, requester index width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- s_req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- s_req_ready_o  out  NUM_REQ  grant/accept; one-hot or zero.
- s_req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- m_data_valid_o  out  1  output register holds a granted item.
- m_data_ready_i  in  1  downstream consumes the item.
- m_data_data_o  out  DATA_WIDTH  latched payload.
- m_data_id_o  out  IDX_WIDTH  index of the requester that won.
- flush_i  in  1  synchronous flush request.
- m_status_busy_o  out  1  output register FULL.
- m_status_flushed_o  out  1  flush completed this cycle.

Behaviour:
- Reset: asynchronous on rst_ni low, independent of the clock.
  - state=EMPTY, ptr=0, data_q=0, id_q=0.
  - m_data_valid_o=0, m_status_busy_o=0.
- States: EMPTY (no item held), FULL (item held, m_data_valid_o=1).
- Winner selection g:
  - g = first index with s_req_valid_i set, searching ptr, ptr+1, ... NUM_REQ-1, 0, ..., ptr-1.
  - any_req = |s_req_valid_i.
- accept = any_req && !flush_i && (state==EMPTY || m_data_ready_i).
- s_req_ready_o = onehot(g) when accept, else all zero. Ready is combinational in the same cycle.
- On accept at the clock edge:
  - data_q <= payload[g], id_q <= g, state <= FULL.
  - ptr <= (g==NUM_REQ-1) ? 0 : g+1.
- EMPTY transitions:
  - accept -> FULL.
  - otherwise stay EMPTY; data_q and id_q keep their values.
- FULL transitions:
  - m_data_ready_i && accept -> FULL with the new item (back-to-back, 1 item/cycle).
  - m_data_ready_i && !any_req -> EMPTY.
  - !m_data_ready_i -> hold; data_q, id_q and m_data_valid_o are stable; all s_req_ready_o = 0.
- Latency: 1 cycle from grant to m_data_valid_o. No combinational path from s_req_data_i to m_data_data_o.
- Flush:
  - flush_i=1 dominates accept and handshakes: all s_req_ready_o=0.
  - Next edge: state <= EMPTY, data_q <= 0, id_q <= 0. ptr is unchanged.
  - A held item is dropped even if m_data_ready_i=1 in that cycle.
  - m_status_flushed_o = flush_i (combinational; one-cycle flush).
- m_status_busy_o = (state==FULL). m_data_valid_o = (state==FULL).
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Requesters drop valid only after seeing ready; the arbiter does not check this.
- Reset mid-operation: the held item is discarded immediately and m_data_valid_o falls without a clock edge.

Test Plan:
1. Reset, then rst_ni=1 with no requests -> m_data_valid_o=0, s_req_ready_o=3'b000, m_status_busy_o=0, first full-contention grant is index 0.
2. Only requester 1 valid with 0xA5 -> s_req_ready_o=3'b010 same cycle; next cycle m_data_valid_o=1, data=0xA5, id=1; with m_data_ready_i=1 and no further requests, EMPTY one cycle later.
3. All three requesters valid continuously, m_data_ready_i=1 -> ids on the output 0,1,2,0,1,2 on consecutive cycles, no bubbles.
4. FULL with id=0, data=0x11; m_data_ready_i=0 for 3 cycles with requesters 1 and 2 valid -> output stable and s_req_ready_o=0 for those cycles. Then m_data_ready_i=1 -> s_req_ready_o=3'b010 and the next output is id=1.
5. FULL, flush_i=1 for one cycle with requester 2 valid and m_data_ready_i=1 -> that cycle: s_req_ready_o=0, m_status_flushed_o=1. Next cycle: m_data_valid_o=0, data=0. ptr is preserved, so the next grant follows the previous winner.
6. rst_ni pulsed low mid-cycle while FULL -> m_data_valid_o=0 immediately without a clock edge. After release, behaviour matches scenario 1.
